// File: rtl/mem_arbiter_if.sv
// Bus bundle between the core-side requesters (IF, LS), the arbiter and the
// word-addressed data RAM. The arbiter takes the slave view; the environment
// (core plus RAM) takes the master view.
interface mem_arbiter_if #(
  parameter int AW = 32
);
  // Instruction fetch requester
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [31:0]   if_rdata;
  logic          if_err;

  // Load/store requester
  logic          ls_req;
  logic          ls_we;
  logic [AW-1:0] ls_addr;
  logic [3:0]    ls_be;
  logic [31:0]   ls_wdata;
  logic          ls_gnt;
  logic          ls_rvalid;
  logic [31:0]   ls_rdata;
  logic          ls_err;

  // Single-port RAM
  logic [31:0]   ram_address;
  logic [3:0]    ram_byteena;
  logic [31:0]   ram_data;
  logic          ram_wren;
  logic [31:0]   ram_q;

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata, if_err,
    input  ls_req, ls_we, ls_addr, ls_be, ls_wdata,
    output ls_gnt, ls_rvalid, ls_rdata, ls_err,
    output ram_address, ram_byteena, ram_data, ram_wren,
    input  ram_q
  );

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata, if_err,
    output ls_req, ls_we, ls_addr, ls_be, ls_wdata,
    input  ls_gnt, ls_rvalid, ls_rdata, ls_err,
    input  ram_address, ram_byteena, ram_data, ram_wren,
    output ram_q
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port data RAM between instruction
// fetch and load/store. Grants are combinational, one access is issued per
// cycle, and the response returns to its owner one cycle later. Accesses
// beyond the RAM depth are granted but never reach the RAM; they come back
// flagged with err.
module mem_arbiter #(
  parameter int DEPTH_WORDS = 8,
  parameter int AW          = 32
) (
  input logic          clock,
  input logic          reset,
  mem_arbiter_if.slave bus
);

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_t;

  // Arbitration state: which requester won the most recent grant
  owner_t      rr_last;

  // One-deep response tracker for the access issued last cycle
  logic        rsp_valid;
  owner_t      rsp_owner;
  logic        rsp_err;
  logic        rsp_write;
  logic [3:0]  rsp_be;

  // Decoded request fields
  logic [31:0] if_word;
  logic [31:0] ls_word;
  logic        if_oor;
  logic        ls_oor;
  logic        unused_addr_lsbs;

  // Grant and issue signals
  logic        if_gnt;
  logic        ls_gnt;
  logic [31:0] ram_address;
  logic [3:0]  ram_byteena;
  logic [31:0] ram_data;
  logic        ram_wren;
  logic        issue_err;
  logic        issue_write;
  logic [3:0]  issue_be;

  // Response signals
  logic        rsp_live;
  logic [31:0] lane_mask;
  logic [31:0] rsp_data;
  logic        if_rvalid;
  logic        ls_rvalid;
  logic [31:0] if_rdata;
  logic [31:0] ls_rdata;
  logic        if_err;
  logic        ls_err;

  // Byte addresses become word indices; the low two bits select nothing.
  assign if_word          = 32'(bus.if_addr[AW-1:2]);
  assign ls_word          = 32'(bus.ls_addr[AW-1:2]);
  assign if_oor           = (if_word >= 32'(DEPTH_WORDS));
  assign ls_oor           = (ls_word >= 32'(DEPTH_WORDS));
  assign unused_addr_lsbs = ^{bus.if_addr[1:0], bus.ls_addr[1:0]};

  // Grant: a lone requester wins; on contention the one that did not win last.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves a signal unassigned and no latch is inferred.
    if_gnt = 1'b0;
    ls_gnt = 1'b0;
    if (!reset) begin
      if (bus.if_req && (!bus.ls_req || rr_last == OWN_LS)) begin
        if_gnt = 1'b1;
      end else if (bus.ls_req) begin
        ls_gnt = 1'b1;
      end
    end
  end

  // Issue: drive the RAM for the granted access; out-of-range accesses and
  // idle cycles leave byteena and wren low so the RAM sees nothing.
  always_comb begin
    ram_address = '0;
    ram_byteena = 4'h0;
    ram_data    = '0;
    ram_wren    = 1'b0;
    issue_err   = 1'b0;
    issue_write = 1'b0;
    issue_be    = 4'h0;
    if (if_gnt) begin
      ram_address = if_word;
      issue_err   = if_oor;
      if (!if_oor) begin
        ram_byteena = 4'hF;
        issue_be    = 4'hF;
      end
    end else if (ls_gnt) begin
      ram_address = ls_word;
      issue_err   = ls_oor;
      issue_write = bus.ls_we;
      if (!ls_oor) begin
        ram_byteena = bus.ls_be;
        if (bus.ls_we) begin
          ram_wren = 1'b1;
          ram_data = bus.ls_wdata;
        end else begin
          issue_be = bus.ls_be;
        end
      end
    end
  end

  // Arbitration and response-tracking registers.
  always_ff @(posedge clock) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (reset) begin
      rr_last   <= OWN_LS;
      rsp_valid <= 1'b0;
      rsp_owner <= OWN_IF;
      rsp_err   <= 1'b0;
      rsp_write <= 1'b0;
      rsp_be    <= 4'h0;
    end else begin
      if (if_gnt) begin
        rr_last <= OWN_IF;
      end else if (ls_gnt) begin
        rr_last <= OWN_LS;
      end
      rsp_valid <= if_gnt || ls_gnt;
      rsp_owner <= ls_gnt ? OWN_LS : OWN_IF;
      rsp_err   <= issue_err;
      rsp_write <= issue_write;
      rsp_be    <= issue_be;
    end
  end

  // Response: route RAM data to the owner, zeroing unrequested lanes. A reset
  // arriving in the response cycle swallows the response.
  always_comb begin
    rsp_live  = rsp_valid && !reset;
    lane_mask = {{8{rsp_be[3]}}, {8{rsp_be[2]}}, {8{rsp_be[1]}}, {8{rsp_be[0]}}};
    rsp_data  = (rsp_err || rsp_write) ? 32'h0 : (bus.ram_q & lane_mask);
    if_rvalid = rsp_live && (rsp_owner == OWN_IF);
    ls_rvalid = rsp_live && (rsp_owner == OWN_LS);
    if_err    = if_rvalid && rsp_err;
    ls_err    = ls_rvalid && rsp_err;
    if_rdata  = if_rvalid ? rsp_data : 32'h0;
    ls_rdata  = ls_rvalid ? rsp_data : 32'h0;
  end

  assign bus.if_gnt      = if_gnt;
  assign bus.ls_gnt      = ls_gnt;
  assign bus.if_rvalid   = if_rvalid;
  assign bus.ls_rvalid   = ls_rvalid;
  assign bus.if_rdata    = if_rdata;
  assign bus.ls_rdata    = ls_rdata;
  assign bus.if_err      = if_err;
  assign bus.ls_err      = ls_err;
  assign bus.ram_address = ram_address;
  assign bus.ram_byteena = ram_byteena;
  assign bus.ram_data    = ram_data;
  assign bus.ram_wren    = ram_wren;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a RAM model hangs off the RAM port, a reference
// model predicts grants, RAM strobes and responses, and a separate monitor
// pops expected responses as the arbiter presents them.
module tb_mem_arbiter;

  localparam int DEPTH = 8;

  typedef struct {
    int          due;
    logic [31:0] data;
    logic        err;
  } rsp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   checks   = 0;
  int   failures = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  mem_arbiter_if #(.AW(32)) u_bus ();

  mem_arbiter #(.DEPTH_WORDS(DEPTH), .AW(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (u_bus)
  );

  // RAM model: registered read, per-byte write, contents loaded once.
  logic [31:0] seed     [DEPTH];
  logic [31:0] ram_mem  [DEPTH];
  bit          ram_loaded = 1'b0;

  always @(posedge clock) begin
    if (!ram_loaded) begin
      for (int i = 0; i < DEPTH; i++) ram_mem[i] <= seed[i];
      ram_loaded <= 1'b1;
    end else if (u_bus.ram_wren && u_bus.ram_address < DEPTH) begin
      for (int b = 0; b < 4; b++)
        if (u_bus.ram_byteena[b])
          ram_mem[u_bus.ram_address[2:0]][8*b +: 8] <= u_bus.ram_data[8*b +: 8];
    end
    u_bus.ram_q <= (u_bus.ram_address < DEPTH) ? ram_mem[u_bus.ram_address[2:0]] : 32'h0;
  end

  // Reference model state
  logic [31:0] ref_mem [DEPTH];
  bit          last_ls = 1'b1;
  rsp_t        q_if[$];
  rsp_t        q_ls[$];

  // Pending requests (held until granted)
  bit          p_if = 1'b0;
  logic [31:0] p_if_addr = '0;
  bit          p_ls = 1'b0;
  bit          p_ls_we = 1'b0;
  logic [31:0] p_ls_addr = '0;
  logic [3:0]  p_ls_be = '0;
  logic [31:0] p_ls_wd = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic post_if(input logic [31:0] addr);
    p_if      = 1'b1;
    p_if_addr = addr;
  endtask

  task automatic post_ls(input bit we, input logic [31:0] addr, input logic [3:0] be,
                         input logic [31:0] wd);
    p_ls      = 1'b1;
    p_ls_we   = we;
    p_ls_addr = addr;
    p_ls_be   = be;
    p_ls_wd   = wd;
  endtask

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(0, 7) == 0) return $urandom();
    return 32'($urandom_range(0, 47));
  endfunction

  // One clock cycle: drive pending requests, predict and check grant and RAM
  // strobes, then advance the reference model.
  task automatic step(input bit rst);
    bit          exp_if, exp_ls, inr;
    logic [31:0] idx, exp_addr, data, mask;
    logic [3:0]  exp_be;
    bit          exp_wren;
    rsp_t        e;
    @(negedge clock);
    reset            = rst;
    u_bus.if_req     = p_if;
    u_bus.if_addr    = p_if_addr;
    u_bus.ls_req     = p_ls;
    u_bus.ls_we      = p_ls_we;
    u_bus.ls_addr    = p_ls_addr;
    u_bus.ls_be      = p_ls_be;
    u_bus.ls_wdata   = p_ls_wd;
    #1;
    exp_if   = !rst && p_if && (!p_ls || last_ls);
    exp_ls   = !rst && p_ls && !exp_if;
    exp_addr = '0;
    exp_be   = 4'h0;
    exp_wren = 1'b0;
    check("if_gnt", u_bus.if_gnt, exp_if);
    check("ls_gnt", u_bus.ls_gnt, exp_ls);
    if (rst) begin
      if (q_if.size() > 0 && q_if[0].due == cyc) void'(q_if.pop_front());
      if (q_ls.size() > 0 && q_ls[0].due == cyc) void'(q_ls.pop_front());
      last_ls = 1'b1;
    end
    if (exp_if) begin
      idx      = p_if_addr >> 2;
      inr      = idx < DEPTH;
      exp_addr = idx;
      exp_be   = inr ? 4'hF : 4'h0;
      e.due    = cyc + 1;
      e.err    = !inr;
      e.data   = inr ? ref_mem[idx[2:0]] : 32'h0;
      q_if.push_back(e);
      last_ls  = 1'b0;
      p_if     = 1'b0;
    end
    if (exp_ls) begin
      idx      = p_ls_addr >> 2;
      inr      = idx < DEPTH;
      exp_addr = idx;
      exp_be   = inr ? p_ls_be : 4'h0;
      exp_wren = inr && p_ls_we;
      mask     = '0;
      for (int b = 0; b < 4; b++) if (p_ls_be[b]) mask[8*b +: 8] = 8'hFF;
      data = 32'h0;
      if (inr && p_ls_we) begin
        ref_mem[idx[2:0]] = (ref_mem[idx[2:0]] & ~mask) | (p_ls_wd & mask);
      end else if (inr) begin
        data = ref_mem[idx[2:0]] & mask;
      end
      e.due   = cyc + 1;
      e.err   = !inr;
      e.data  = data;
      q_ls.push_back(e);
      last_ls = 1'b1;
      p_ls    = 1'b0;
    end
    check("ram_byteena", u_bus.ram_byteena, exp_be);
    check("ram_wren", u_bus.ram_wren, exp_wren);
    if (exp_if || exp_ls) check("ram_address", u_bus.ram_address, exp_addr);
    if (exp_wren) check("ram_data", u_bus.ram_data, p_ls_wd);
  endtask

  // Monitor one response channel against its expectation queue.
  task automatic mon_side(input int s, input logic rv, input logic [31:0] rd, input logic er);
    string nm;
    bit    have;
    rsp_t  e;
    nm   = (s == 0) ? "if" : "ls";
    have = (s == 0) ? (q_if.size() > 0) : (q_ls.size() > 0);
    if (have) e = (s == 0) ? q_if[0] : q_ls[0];
    if (rv) begin
      if (!have) begin
        check({nm, "_rvalid_unexpected"}, rv, 1'b0);
      end else begin
        if (s == 0) void'(q_if.pop_front()); else void'(q_ls.pop_front());
        check({nm, "_latency"}, cyc, e.due);
        check({nm, "_rdata"}, rd, e.data);
        check({nm, "_err"}, er, e.err);
      end
    end else begin
      check({nm, "_err_idle"}, er, 1'b0);
      check({nm, "_rdata_idle"}, rd, 32'h0);
      if (have && e.due <= cyc) begin
        check({nm, "_rvalid"}, rv, 1'b1);
        if (s == 0) void'(q_if.pop_front()); else void'(q_ls.pop_front());
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clock);
      #2;
      mon_side(0, u_bus.if_rvalid, u_bus.if_rdata, u_bus.if_err);
      mon_side(1, u_bus.ls_rvalid, u_bus.ls_rdata, u_bus.ls_err);
    end
  end

  initial begin
    u_bus.if_req   = 1'b0;
    u_bus.if_addr  = '0;
    u_bus.ls_req   = 1'b0;
    u_bus.ls_we    = 1'b0;
    u_bus.ls_addr  = '0;
    u_bus.ls_be    = '0;
    u_bus.ls_wdata = '0;
    for (int i = 0; i < DEPTH; i++) begin
      seed[i]    = $urandom();
      ref_mem[i] = seed[i];
    end

    // Reset held with no requests
    repeat (3) step(1'b1);

    // Write then read back the same word
    post_ls(1'b1, 32'h8, 4'hF, 32'hDEADBEEF);
    step(1'b0);
    post_if(32'h8);
    step(1'b0);
    repeat (2) step(1'b0);

    // Partial write and masked reads
    post_ls(1'b1, 32'h4, 4'hF, 32'h11223344);
    step(1'b0);
    post_ls(1'b1, 32'h4, 4'b0010, 32'h0000AB00);
    step(1'b0);
    post_ls(1'b0, 32'h4, 4'hF, 32'h0);
    step(1'b0);
    post_ls(1'b0, 32'h4, 4'b0001, 32'h0);
    step(1'b0);
    post_ls(1'b0, 32'h10, 4'h0, 32'h0);
    step(1'b0);

    // Back-to-back contention straight out of reset
    repeat (2) step(1'b1);
    for (int k = 0; k < 4; k++) begin
      if (!p_if) post_if(32'($urandom_range(0, 31)));
      if (!p_ls) post_ls(1'b0, 32'($urandom_range(0, 31)), 4'hF, 32'h0);
      step(1'b0);
    end
    repeat (3) step(1'b0);

    // Out-of-range write, then read back every word
    post_ls(1'b1, 32'h20, 4'hF, 32'hCAFEF00D);
    step(1'b0);
    for (int w = 0; w < DEPTH; w++) begin
      post_ls(1'b0, 32'(w * 4), 4'hF, 32'h0);
      step(1'b0);
    end

    // Reset in the response cycle of an IF grant, then contention
    post_if(32'hC);
    step(1'b0);
    step(1'b1);
    post_if(32'h0);
    post_ls(1'b0, 32'h4, 4'hF, 32'h0);
    step(1'b0);
    repeat (2) step(1'b0);

    // Randomized traffic with occasional resets
    for (int k = 0; k < 400; k++) begin
      if (!p_if && $urandom_range(0, 3) != 0) post_if(rand_addr());
      if (!p_ls && $urandom_range(0, 3) != 0)
        post_ls(1'($urandom_range(0, 1)), rand_addr(), 4'($urandom_range(0, 15)), $urandom());
      step($urandom_range(0, 59) == 0);
    end

    // Drain
    for (int k = 0; k < 6 && (p_if || p_ls); k++) step(1'b0);
    repeat (3) step(1'b0);
    check("if_queue_drained", 32'(q_if.size()), 32'h0);
    check("ls_queue_drained", 32'(q_ls.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
